eth_frame_parser: RTL and testbench
===================================

// Module: eth_frame_parser
// PURPOSE
//  Byte-wide GMII RX frame parser: checks preamble/SFD, tags each byte with its field, captures DA/SA/EtherType.
//  Optional: 802.1Q tag. Enforces configurable min/max length; drops bad frames up to the next idle gap.
//  Sits between GMII RX pipe and CRC checker / RX FIFO.
// PARAMETERS
//  PREAMBLE_LEN     7     preamble bytes (0x55) before SFD
//  MIN_PAYLOAD_LEN  46    min payload bytes (excl. CRC, excl. VLAN tag)
//  MAX_PAYLOAD_LEN  1500  max payload bytes (excl. CRC, excl. VLAN tag)
//  CRC_LEN          4     FCS bytes counted with payload
// PORTS
//  clk                 in   1   clock
//  rst_n               in   1   synchronous reset, active-low
//  rx_valid_i          in   1   GMII RX_DV
//  rx_er_i             in   1   GMII RX_ER
//  rx_data_i           in   8   GMII RXD
//  is_preamble_sfd_o   out  1   current byte is preamble/SFD (comb. from state)
//  is_dst_mac_o / is_src_mac_o / is_vlan_o / is_ether_type_o  out 1 each  field strobes (comb.)
//  is_payload_or_crc_o out  1   byte is payload/FCS (state==PAYLOAD && rx_valid_i)
//  dst_mac_o, src_mac_o out 48  captured MACs, first byte on wire in [47:40]
//  ether_type_o        out  16  captured EtherType (inner type when tagged)
//  vlan_present_o      out  1   frame carried 0x8100 tag
//  vlan_tci_o          out  16  captured TCI
//  frame_len_o         out  LEN_W  payload+FCS bytes of last frame
//  frame_done_o        out  1   1-cycle pulse, frame ended (good or bad)
//  frame_ok_o          out  1   qualifies frame_done_o: no error
//  err_preamble_sfd_o / err_truncated_o / err_runt_o / err_oversize_o / err_rx_o  out 1 each  1-cycle pulses
// BEHAVIOUR
//  Reset: all outputs 0; state=DROP; counters 0. Reset mid-frame aborts silently, no error pulse.
//  States: IDLE, PREAMBLE, SFD, DST_MAC, SRC_MAC, [VLAN], ETHER_TYPE, PAYLOAD, DROP.
//  IDLE: rx_valid_i high -> check byte==0x55, cnt=1, ->PREAMBLE (PREAMBLE_LEN==1 -> SFD).
//  PREAMBLE: each byte==0x55; after PREAMBLE_LEN bytes ->SFD. SFD: byte==0xD5 -> DST_MAC.
//  DST_MAC/SRC_MAC: 6 bytes each, shifted into register. ETHER_TYPE: 2 bytes.
//  Ethertype 0x8100 + VLAN enabled -> VLAN (2 TCI bytes) -> ETHER_TYPE again; else ->PAYLOAD.
//  Captured fields update in place; stable from cycle after last field byte until next frame's DA.
//  PAYLOAD: count bytes (saturating at limit+1). rx_valid_i low -> IDLE, frame_done_o next cycle,
//   frame_len_o=count; count < MIN+CRC -> err_runt_o, frame_ok_o=0.
//   count == MAX+CRC(+4 if tagged) and rx_valid_i still high -> err_oversize_o, ->DROP.
//  rx_valid_i low in PREAMBLE..ETHER_TYPE -> err_truncated_o, ->IDLE.
//  Preamble/SFD mismatch -> err_preamble_sfd_o, ->DROP.
//  rx_er_i && rx_valid_i, any non-IDLE/non-DROP state -> err_rx_o, ->DROP. rx_er_i ignored when valid low.
//  DROP: ignore bytes; rx_valid_i low -> IDLE. Exactly one frame_done_o per frame, incl. dropped ones.
//  Error priority per cycle: rx_er > preamble/sfd > oversize > truncated/runt; one error pulse per frame.
//  Error pulses coincide with frame_done_o (frame_ok_o=0). Back-to-back frames need >=1 idle cycle.
//  LEN_W = $clog2(MAX_PAYLOAD_LEN+CRC_LEN+4+2).
// CONFIGURATION
//  ETH_PARSER_VLAN_EN defined: VLAN state, tag recognition, +4 byte max allowance.
//  Undefined: 0x8100 is an ordinary EtherType; vlan_present_o, vlan_tci_o, is_vlan_o tied 0.
// STRUCTURE
//  eth_parser_pkg: parser_state_t (incl. VLAN, DROP), PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5,
//   TPID_VLAN=16'h8100, MAC_LEN=6, ETHER_TYPE_LEN=2, VLAN_TAG_LEN=2, preamble_error/sfd_error functions.
//  Sub-module eth_field_capture: byte-enable shift registers for DA/SA/TCI/EtherType.
// TESTING
//  7x55,D5, DA 01..06, SA 0A..0F, type 0800, 46B+4 FCS -> frame_done_o, frame_ok_o=1, frame_len_o=50.
//  Same frame, 40B payload+FCS -> err_runt_o, frame_ok_o=0, frame_len_o=44.
//  1505B payload+FCS, untagged -> err_oversize_o on byte 1505; DROP until valid low; frame_done_o once.
//  SFD=0xD4 -> err_preamble_sfd_o; next good frame after gap parsed OK.
//  VLAN_EN, type 8100 TCI 0064 type 86DD -> vlan_present_o=1, vlan_tci_o=0064, ether_type_o=86DD, 1508B+FCS passes.
//  rx_er_i in SRC_MAC -> err_rx_o; rx_valid_i drop in DST_MAC -> err_truncated_o; rst_n low mid-payload -> no pulse.

Source files
------------

// File: rtl/eth_parser_pkg.sv
// Shared definitions for the GMII RX frame parser: state encoding, on-wire
// constants, field lengths and the preamble/SFD byte checks.
package eth_parser_pkg;

  // Parser states. Plain 4-bit constants so older tools that dislike enums
  // in port lists still accept them.
  typedef logic [3:0] parser_state_t;

  localparam parser_state_t ST_IDLE       = 4'd0;
  localparam parser_state_t ST_PREAMBLE   = 4'd1;
  localparam parser_state_t ST_SFD        = 4'd2;
  localparam parser_state_t ST_DST_MAC    = 4'd3;
  localparam parser_state_t ST_SRC_MAC    = 4'd4;
  localparam parser_state_t ST_VLAN       = 4'd5;
  localparam parser_state_t ST_ETHER_TYPE = 4'd6;
  localparam parser_state_t ST_PAYLOAD    = 4'd7;
  localparam parser_state_t ST_DROP       = 4'd8;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] TPID_VLAN     = 16'h8100;

  localparam int MAC_LEN        = 6;
  localparam int ETHER_TYPE_LEN = 2;
  localparam int VLAN_TAG_LEN   = 2;

  // True when a byte expected to be preamble is anything other than 0x55.
  function automatic logic preamble_error(input logic [7:0] b);
    return (b != PREAMBLE_BYTE);
  endfunction

  // True when the start-of-frame delimiter byte is not 0xD5.
  function automatic logic sfd_error(input logic [7:0] b);
    return (b != SFD_BYTE);
  endfunction

endpackage

// File: rtl/eth_field_capture.sv
// Header field capture for the frame parser. Each field is a byte-enabled
// shift register: the first byte on the wire ends up in the top byte.
// Fields are held until their enable fires again (next frame).
module eth_field_capture
  import eth_parser_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             data_i,
  input  logic                   dst_en_i,
  input  logic                   src_en_i,
  input  logic                   tci_en_i,
  input  logic                   type_en_i,
  output logic [8*MAC_LEN-1:0]   dst_mac_o,
  output logic [8*MAC_LEN-1:0]   src_mac_o,
  output logic [15:0]            tci_o,
  output logic [15:0]            ether_type_o
);

  localparam int MAC_W = 8 * MAC_LEN;

  logic [MAC_W-1:0] dst_mac_q, dst_mac_d;
  logic [MAC_W-1:0] src_mac_q, src_mac_d;
  logic [15:0]      tci_q, tci_d;
  logic [15:0]      ether_type_q, ether_type_d;

  // Shift the current byte into whichever field is being received.
  always_comb begin
    dst_mac_d    = dst_mac_q;
    src_mac_d    = src_mac_q;
    tci_d        = tci_q;
    ether_type_d = ether_type_q;
    if (dst_en_i)  dst_mac_d    = {dst_mac_q[MAC_W-9:0], data_i};
    if (src_en_i)  src_mac_d    = {src_mac_q[MAC_W-9:0], data_i};
    if (tci_en_i)  tci_d        = {tci_q[7:0], data_i};
    if (type_en_i) ether_type_d = {ether_type_q[7:0], data_i};
  end

  // Field registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dst_mac_q    <= '0;
      src_mac_q    <= '0;
      tci_q        <= '0;
      ether_type_q <= '0;
    end else begin
      dst_mac_q    <= dst_mac_d;
      src_mac_q    <= src_mac_d;
      tci_q        <= tci_d;
      ether_type_q <= ether_type_d;
    end
  end

  assign dst_mac_o    = dst_mac_q;
  assign src_mac_o    = src_mac_q;
  assign tci_o        = tci_q;
  assign ether_type_o = ether_type_q;

endmodule

// File: rtl/eth_frame_parser.sv
// Byte-wide GMII RX frame parser. Validates preamble/SFD, tags every byte
// with its header field, captures DA/SA/EtherType and enforces payload
// length limits. Bad frames are dropped up to the next idle gap and every
// frame, good or bad, ends with exactly one frame_done_o pulse.
// Build option: define ETH_PARSER_VLAN_EN to recognise a single 802.1Q tag
// (adds the VLAN state and a 4-byte max-length allowance); without it
// 0x8100 is an ordinary EtherType and the VLAN outputs stay 0.
module eth_frame_parser
  import eth_parser_pkg::*;
#(
  parameter int PREAMBLE_LEN    = 7,
  parameter int MIN_PAYLOAD_LEN = 46,
  parameter int MAX_PAYLOAD_LEN = 1500,
  parameter int CRC_LEN         = 4,
  parameter int LEN_W           = $clog2(MAX_PAYLOAD_LEN + CRC_LEN + 4 + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid_i,
  input  logic             rx_er_i,
  input  logic [7:0]       rx_data_i,
  output logic             is_preamble_sfd_o,
  output logic             is_dst_mac_o,
  output logic             is_src_mac_o,
  output logic             is_vlan_o,
  output logic             is_ether_type_o,
  output logic             is_payload_or_crc_o,
  output logic [47:0]      dst_mac_o,
  output logic [47:0]      src_mac_o,
  output logic [15:0]      ether_type_o,
  output logic             vlan_present_o,
  output logic [15:0]      vlan_tci_o,
  output logic [LEN_W-1:0] frame_len_o,
  output logic             frame_done_o,
  output logic             frame_ok_o,
  output logic             err_preamble_sfd_o,
  output logic             err_truncated_o,
  output logic             err_runt_o,
  output logic             err_oversize_o,
  output logic             err_rx_o
);

  localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] MAC_LAST  = 8'(MAC_LEN - 1);
  localparam logic [7:0] TYPE_LAST = 8'(ETHER_TYPE_LEN - 1);
  localparam logic [LEN_W-1:0] RUNT_LIM  = LEN_W'(MIN_PAYLOAD_LEN + CRC_LEN);
  localparam logic [LEN_W-1:0] MAX_PLAIN = LEN_W'(MAX_PAYLOAD_LEN + CRC_LEN);
  localparam logic [LEN_W-1:0] MAX_TAG   = LEN_W'(MAX_PAYLOAD_LEN + CRC_LEN + 4);

  parser_state_t    state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0] pay_cnt_q, pay_cnt_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             tagged_q, tagged_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             err_rx_q, err_rx_d;
  logic             err_pre_q, err_pre_d;
  logic             err_over_q, err_over_d;
  logic             err_trunc_q, err_trunc_d;
  logic             err_runt_q, err_runt_d;
  logic [LEN_W-1:0] max_len;

`ifdef ETH_PARSER_VLAN_EN
  logic [15:0]      type_word;
  assign type_word = {ether_type_o[7:0], rx_data_i};
`endif

  // A tagged frame may carry four more bytes before it counts as oversize.
  assign max_len = tagged_q ? MAX_TAG : MAX_PLAIN;

  // Next-state, counters and end-of-frame status for the current byte.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pay_cnt_d   = pay_cnt_q;
    frame_len_d = frame_len_q;
    tagged_d    = tagged_q;
    done_d      = 1'b0;
    ok_d        = 1'b0;
    err_rx_d    = 1'b0;
    err_pre_d   = 1'b0;
    err_over_d  = 1'b0;
    err_trunc_d = 1'b0;
    err_runt_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid_i) begin
          pay_cnt_d = '0;
          if (preamble_error(rx_data_i)) begin
            err_pre_d   = 1'b1;
            done_d      = 1'b1;
            frame_len_d = '0;
            state_d     = ST_DROP;
          end else begin
            cnt_d   = 8'd1;
            state_d = (PREAMBLE_LEN == 1) ? ST_SFD : ST_PREAMBLE;
          end
        end
      end

      ST_DROP: begin
        if (!rx_valid_i) state_d = ST_IDLE;
      end

      default: begin
        if (rx_valid_i && rx_er_i) begin
          // Symbol error outranks everything else seen on this byte.
          err_rx_d    = 1'b1;
          done_d      = 1'b1;
          frame_len_d = pay_cnt_q;
          state_d     = ST_DROP;
        end else if (!rx_valid_i) begin
          // End of carrier: normal end in payload, truncation elsewhere.
          done_d      = 1'b1;
          frame_len_d = pay_cnt_q;
          state_d     = ST_IDLE;
          if (state_q == ST_PAYLOAD) begin
            if (pay_cnt_q < RUNT_LIM) err_runt_d = 1'b1;
            else                      ok_d       = 1'b1;
          end else begin
            err_trunc_d = 1'b1;
          end
        end else begin
          case (state_q)
            ST_PREAMBLE: begin
              if (preamble_error(rx_data_i)) begin
                err_pre_d   = 1'b1;
                done_d      = 1'b1;
                frame_len_d = pay_cnt_q;
                state_d     = ST_DROP;
              end else begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == PRE_LAST) state_d = ST_SFD;
              end
            end
            ST_SFD: begin
              if (sfd_error(rx_data_i)) begin
                err_pre_d   = 1'b1;
                done_d      = 1'b1;
                frame_len_d = pay_cnt_q;
                state_d     = ST_DROP;
              end else begin
                cnt_d   = '0;
                state_d = ST_DST_MAC;
              end
            end
            ST_DST_MAC: begin
              // The tag flag belongs to the previous frame until a new DA starts.
              if (cnt_q == '0) tagged_d = 1'b0;
              if (cnt_q == MAC_LAST) begin
                cnt_d   = '0;
                state_d = ST_SRC_MAC;
              end else begin
                cnt_d = cnt_q + 8'd1;
              end
            end
            ST_SRC_MAC: begin
              if (cnt_q == MAC_LAST) begin
                cnt_d   = '0;
                state_d = ST_ETHER_TYPE;
              end else begin
                cnt_d = cnt_q + 8'd1;
              end
            end
            ST_ETHER_TYPE: begin
              if (cnt_q == TYPE_LAST) begin
                cnt_d   = '0;
                state_d = ST_PAYLOAD;
`ifdef ETH_PARSER_VLAN_EN
                // Only one tag is recognised; a second 0x8100 is payload type.
                if (!tagged_q && (type_word == TPID_VLAN)) begin
                  tagged_d = 1'b1;
                  state_d  = ST_VLAN;
                end
`endif
              end else begin
                cnt_d = cnt_q + 8'd1;
              end
            end
`ifdef ETH_PARSER_VLAN_EN
            ST_VLAN: begin
              if (cnt_q == 8'(VLAN_TAG_LEN - 1)) begin
                cnt_d   = '0;
                state_d = ST_ETHER_TYPE;
              end else begin
                cnt_d = cnt_q + 8'd1;
              end
            end
`endif
            ST_PAYLOAD: begin
              if (pay_cnt_q == max_len) begin
                // One byte past the limit: report length as limit+1 and drop.
                pay_cnt_d   = pay_cnt_q + 1'b1;
                err_over_d  = 1'b1;
                done_d      = 1'b1;
                frame_len_d = pay_cnt_q + 1'b1;
                state_d     = ST_DROP;
              end else begin
                pay_cnt_d = pay_cnt_q + 1'b1;
              end
            end
            default: state_d = ST_DROP;
          endcase
        end
      end
    endcase
  end

  // State, counters and registered status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_DROP;
      cnt_q       <= '0;
      pay_cnt_q   <= '0;
      frame_len_q <= '0;
      tagged_q    <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      err_rx_q    <= 1'b0;
      err_pre_q   <= 1'b0;
      err_over_q  <= 1'b0;
      err_trunc_q <= 1'b0;
      err_runt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      frame_len_q <= frame_len_d;
      tagged_q    <= tagged_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      err_rx_q    <= err_rx_d;
      err_pre_q   <= err_pre_d;
      err_over_q  <= err_over_d;
      err_trunc_q <= err_trunc_d;
      err_runt_q  <= err_runt_d;
    end
  end

  // Field strobes describe the byte currently on rx_data_i.
  assign is_preamble_sfd_o   = rx_valid_i && ((state_q == ST_IDLE) ||
                                              (state_q == ST_PREAMBLE) ||
                                              (state_q == ST_SFD));
  assign is_dst_mac_o        = rx_valid_i && (state_q == ST_DST_MAC);
  assign is_src_mac_o        = rx_valid_i && (state_q == ST_SRC_MAC);
  assign is_ether_type_o     = rx_valid_i && (state_q == ST_ETHER_TYPE);
  assign is_payload_or_crc_o = rx_valid_i && (state_q == ST_PAYLOAD);
`ifdef ETH_PARSER_VLAN_EN
  assign is_vlan_o           = rx_valid_i && (state_q == ST_VLAN);
`else
  assign is_vlan_o           = 1'b0;
`endif

  eth_field_capture u_capture (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (rx_data_i),
    .dst_en_i     (is_dst_mac_o),
    .src_en_i     (is_src_mac_o),
    .tci_en_i     (is_vlan_o),
    .type_en_i    (is_ether_type_o),
    .dst_mac_o    (dst_mac_o),
    .src_mac_o    (src_mac_o),
    .tci_o        (vlan_tci_o),
    .ether_type_o (ether_type_o)
  );

  assign vlan_present_o     = tagged_q;
  assign frame_len_o        = frame_len_q;
  assign frame_done_o       = done_q;
  assign frame_ok_o         = ok_q;
  assign err_rx_o           = err_rx_q;
  assign err_preamble_sfd_o = err_pre_q;
  assign err_oversize_o     = err_over_q;
  assign err_truncated_o    = err_trunc_q;
  assign err_runt_o         = err_runt_q;

endmodule

// File: tb/tb_eth_frame_parser.sv
// Testbench for eth_frame_parser: table of frames driven byte by byte,
// expected end-of-frame status queued per frame and compared when
// frame_done_o fires, plus hand-written reset and idle-error sequences.
`timescale 1ns/1ps
module tb_eth_frame_parser;

  localparam int LEN_W = 11;

  logic             clk;
  logic             rst_n;
  logic             rx_valid_i;
  logic             rx_er_i;
  logic [7:0]       rx_data_i;
  logic             is_preamble_sfd_o, is_dst_mac_o, is_src_mac_o;
  logic             is_vlan_o, is_ether_type_o, is_payload_or_crc_o;
  logic [47:0]      dst_mac_o, src_mac_o;
  logic [15:0]      ether_type_o, vlan_tci_o;
  logic             vlan_present_o;
  logic [LEN_W-1:0] frame_len_o;
  logic             frame_done_o, frame_ok_o;
  logic             err_preamble_sfd_o, err_truncated_o, err_runt_o;
  logic             err_oversize_o, err_rx_o;

  eth_frame_parser dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rx_valid_i          (rx_valid_i),
    .rx_er_i             (rx_er_i),
    .rx_data_i           (rx_data_i),
    .is_preamble_sfd_o   (is_preamble_sfd_o),
    .is_dst_mac_o        (is_dst_mac_o),
    .is_src_mac_o        (is_src_mac_o),
    .is_vlan_o           (is_vlan_o),
    .is_ether_type_o     (is_ether_type_o),
    .is_payload_or_crc_o (is_payload_or_crc_o),
    .dst_mac_o           (dst_mac_o),
    .src_mac_o           (src_mac_o),
    .ether_type_o        (ether_type_o),
    .vlan_present_o      (vlan_present_o),
    .vlan_tci_o          (vlan_tci_o),
    .frame_len_o         (frame_len_o),
    .frame_done_o        (frame_done_o),
    .frame_ok_o          (frame_ok_o),
    .err_preamble_sfd_o  (err_preamble_sfd_o),
    .err_truncated_o     (err_truncated_o),
    .err_runt_o          (err_runt_o),
    .err_oversize_o      (err_oversize_o),
    .err_rx_o            (err_rx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // err bits: {rx, preamble_sfd, oversize, truncated, runt}
  typedef struct {
    int         pay;
    logic [7:0] sfd;
    bit         tag;
    int         trunc_at;
    int         er_at;
    bit         ok;
    int         len;
    logic [4:0] err;
    bit         chk_f;
    bit         chk_drop;
  } vec_t;

  typedef struct {
    int         id;
    bit         ok;
    int         len;
    logic [4:0] err;
    bit         chk_f;
    bit         chk_drop;
    bit         tag;
    logic [15:0] et;
    bit         vp;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int id, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s (frame %0d): got=%0h expected=%0h", nm, id, got, want);
    end
  endtask

  function automatic vec_t mk(int pay, logic [7:0] sfd, bit tag, int tr, int er,
                              bit ok, int len, logic [4:0] err, bit cf, bit cd);
    vec_t v;
    v.pay = pay; v.sfd = sfd; v.tag = tag; v.trunc_at = tr; v.er_at = er;
    v.ok = ok; v.len = len; v.err = err; v.chk_f = cf; v.chk_drop = cd;
    return v;
  endfunction

  // Scoreboard consumer: one expected record per frame_done_o pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && frame_done_o) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got=1 expected=0");
      end else begin
        e = sb.pop_front();
        chk("frame_ok", e.id, 64'(frame_ok_o), 64'(e.ok));
        chk("frame_len", e.id, 64'(frame_len_o), 64'(e.len));
        chk("err_vec", e.id, 64'({err_rx_o, err_preamble_sfd_o, err_oversize_o,
                                  err_truncated_o, err_runt_o}), 64'(e.err));
        if (e.chk_f) begin
          chk("dst_mac", e.id, 64'(dst_mac_o), 64'h010203040506);
          chk("src_mac", e.id, 64'(src_mac_o), 64'h0a0b0c0d0e0f);
          chk("ether_type", e.id, 64'(ether_type_o), 64'(e.et));
          chk("vlan_present", e.id, 64'(vlan_present_o), 64'(e.vp));
          if (e.tag)
            chk("vlan_tci", e.id, 64'(vlan_tci_o), e.vp ? 64'h0064 : 64'h0);
        end
        if (e.chk_drop)
          chk("drop_after_oversize", e.id, 64'(is_payload_or_crc_o), 64'h0);
      end
    end else if (rst_n && (err_rx_o | err_preamble_sfd_o | err_oversize_o |
                           err_truncated_o | err_runt_o)) begin
      total++; bad++;
      $display("FAIL stray_error_pulse: got=1 expected=0");
    end
  end

  // Drive one frame; rst_at >= 0 aborts with a reset at that byte index.
  task automatic send(input vec_t v, input int id, input int rst_at);
    logic [7:0] b[$];
    exp_t e;
    int n;
    for (int i = 0; i < 7; i++) b.push_back(8'h55);
    b.push_back(v.sfd);
    for (int i = 1; i <= 6; i++) b.push_back(8'(i));
    for (int i = 10; i <= 15; i++) b.push_back(8'(i));
    if (v.tag) begin
      b.push_back(8'h81); b.push_back(8'h00);
      b.push_back(8'h00); b.push_back(8'h64);
      b.push_back(8'h86); b.push_back(8'hDD);
    end else begin
      b.push_back(8'h08); b.push_back(8'h00);
    end
    for (int i = 0; i < v.pay; i++) b.push_back(8'(i * 7 + 3));
    n = (v.trunc_at >= 0) ? v.trunc_at : b.size();
    if (rst_at < 0) begin
      e.id = id; e.ok = v.ok; e.len = v.len; e.err = v.err;
      e.chk_f = v.chk_f; e.chk_drop = v.chk_drop; e.tag = v.tag;
`ifdef ETH_PARSER_VLAN_EN
      e.et = v.tag ? 16'h86DD : 16'h0800;
      e.vp = v.tag;
`else
      e.et = v.tag ? 16'h8100 : 16'h0800;
      e.vp = 1'b0;
`endif
      sb.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == rst_at) begin
        rx_valid_i = 1'b0; rx_er_i = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        break;
      end
      rx_valid_i = 1'b1;
      rx_data_i  = b[i];
      rx_er_i    = (i == v.er_at);
    end
    @(posedge clk); #1;
    rx_valid_i = 1'b0; rx_er_i = 1'b0; rx_data_i = 8'h00;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wait_cyc;
    vec_t good;
    rst_n = 1'b0; rx_valid_i = 1'b0; rx_er_i = 1'b0; rx_data_i = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", -1, 64'(frame_done_o), 64'h0);
    chk("rst_ok", -1, 64'(frame_ok_o), 64'h0);
    chk("rst_len", -1, 64'(frame_len_o), 64'h0);
    chk("rst_dst", -1, 64'(dst_mac_o), 64'h0);
    chk("rst_err", -1, 64'({err_rx_o, err_preamble_sfd_o, err_oversize_o,
                            err_truncated_o, err_runt_o}), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    good = mk(50, 8'hD5, 1'b0, -1, -1, 1'b1, 50, 5'b00000, 1'b1, 1'b0);
    tbl.push_back(good);
    tbl.push_back(mk(44,   8'hD5, 1'b0, -1, -1, 1'b0, 44,   5'b00001, 1'b1, 1'b0));
    tbl.push_back(mk(49,   8'hD5, 1'b0, -1, -1, 1'b0, 49,   5'b00001, 1'b0, 1'b0));
    tbl.push_back(mk(1504, 8'hD5, 1'b0, -1, -1, 1'b1, 1504, 5'b00000, 1'b1, 1'b0));
    tbl.push_back(mk(1510, 8'hD5, 1'b0, -1, -1, 1'b0, 1505, 5'b00100, 1'b0, 1'b1));
    tbl.push_back(mk(50,   8'hD4, 1'b0, -1, -1, 1'b0, 0,    5'b01000, 1'b0, 1'b0));
    tbl.push_back(mk(60,   8'hD5, 1'b0, -1, -1, 1'b1, 60,   5'b00000, 1'b1, 1'b0));
    tbl.push_back(mk(50,   8'hD5, 1'b0, 11, -1, 1'b0, 0,    5'b00010, 1'b0, 1'b0));
    tbl.push_back(mk(50,   8'hD5, 1'b0, -1, 15, 1'b0, 0,    5'b10000, 1'b0, 1'b0));
`ifdef ETH_PARSER_VLAN_EN
    tbl.push_back(mk(1508, 8'hD5, 1'b1, -1, -1, 1'b1, 1508, 5'b00000, 1'b1, 1'b0));
    tbl.push_back(mk(1510, 8'hD5, 1'b1, -1, -1, 1'b0, 1509, 5'b00100, 1'b0, 1'b1));
`else
    tbl.push_back(mk(60,   8'hD5, 1'b1, -1, -1, 1'b1, 64,   5'b00000, 1'b1, 1'b0));
    tbl.push_back(mk(0,    8'hD5, 1'b0, -1, -1, 1'b0, 0,    5'b00001, 1'b0, 1'b0));
`endif
    tbl.push_back(mk(64,   8'hD5, 1'b0, -1, -1, 1'b1, 64,   5'b00000, 1'b1, 1'b0));

    for (int i = 0; i < tbl.size(); i++) send(tbl[i], i, -1);

    // Reset in the middle of the payload: silent abort, outputs cleared.
    send(good, 100, 22 + 20);
    @(negedge clk);
    chk("midrst_dst", 100, 64'(dst_mac_o), 64'h0);
    chk("midrst_len", 100, 64'(frame_len_o), 64'h0);
    chk("midrst_ok", 100, 64'(frame_ok_o), 64'h0);
    send(good, 101, -1);

    // rx_er_i while idle must be ignored.
    @(posedge clk); #1 rx_er_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx_er_i = 1'b0;
    send(good, 102, -1);

    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 50) begin
      @(posedge clk);
      wait_cyc++;
    end
    chk("scoreboard_drained", -2, 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
